// File: rtl/vga_fetch_ctrl.sv
// Pixel-fetch scheduler for the VGA timing generator: prefetches frame-buffer
// pixels into an in-order FIFO and presents them on active pixel cycles.
//
// state | meaning
// IDLE  | fetch disabled, waits for enable before the first active line
// FILL  | issuing read requests for the current frame
// DONE  | whole frame requested, waiting for frame end
// DRAIN | finish pending/outstanding reads, then flush and rewind
module vga_fetch_ctrl #(
  parameter int H_TOTAL    = 800,
  parameter int H_ACT_S    = 145,
  parameter int H_ACT_E    = 784,
  parameter int V_TOTAL    = 525,
  parameter int V_ACT_S    = 36,
  parameter int V_ACT_E    = 515,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [23:0]       mem_rsp_data,
  output logic [23:0]       pix_data,
  output logic              underflow,
  output logic              frame_start
);
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FRAME_PIX = (H_ACT_E - H_ACT_S + 1) * (V_ACT_E - V_ACT_S + 1);
  localparam logic [XW-1:0] HT = XW'(H_TOTAL);
  localparam logic [XW-1:0] HS = XW'(H_ACT_S);
  localparam logic [XW-1:0] HE = XW'(H_ACT_E);
  localparam logic [YW-1:0] VT = YW'(V_TOTAL);
  localparam logic [YW-1:0] VS = YW'(V_ACT_S);
  localparam logic [YW-1:0] VE = YW'(V_ACT_E);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     outstanding;
  logic [ADDR_W-1:0] skip;
  logic              req_pend;
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;

  logic active, frame_end, fifo_empty, credit_ok, accept, rsp_take;
  logic pop, push, underrun, drain_done, skip_dec;
  logic [ADDR_W-1:0] skip_eff, skip_nxt;

  assign active     = (x_cnt >= HS) && (x_cnt <= HE) && (y_cnt >= VS) && (y_cnt <= VE);
  assign frame_end  = (x_cnt == HT) && (y_cnt == VT);
  assign fifo_empty = (fifo_count == '0);
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_MAX;

  // A request once raised is held by req_pend even after leaving FILL.
  assign mem_req_valid = req_pend || ((state == FILL) && credit_ok);
  assign mem_req_addr  = addr;
  assign accept        = mem_req_valid && mem_req_ready;
  assign rsp_take      = mem_rsp_valid && (outstanding != '0);

  assign pop      = active && !fifo_empty;
  assign underrun = active && fifo_empty;
  assign pix_data = pop ? fifo_mem[rd_ptr] : '0;

  // An underrun this cycle claims the response arriving in the same cycle.
  assign skip_eff = skip + ADDR_W'(underrun);
  assign skip_dec = rsp_take && (state != DRAIN) && (skip_eff != '0);
  assign skip_nxt = skip_eff - ADDR_W'(skip_dec);
  assign push     = rsp_take && (state != DRAIN) && (skip_eff == '0);

  assign drain_done = (state == DRAIN) && !req_pend && (outstanding == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && (y_cnt < VS)) state_nxt = FILL;
      FILL:    if (frame_end) state_nxt = DRAIN;
               else if (accept && (addr == LAST_ADDR)) state_nxt = DONE;
      DONE:    if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = enable ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      x_cnt       <= XW'(1);
      y_cnt       <= YW'(1);
      addr        <= '0;
      outstanding <= '0;
      skip        <= '0;
      req_pend    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      underflow   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_nxt;
      if (x_cnt == HT) begin
        x_cnt <= XW'(1);
        y_cnt <= (y_cnt == VT) ? YW'(1) : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
      frame_start <= frame_end;
      req_pend    <= mem_req_valid && !mem_req_ready;
      outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
      if (underrun) underflow <= 1'b1;
      if (drain_done) begin
        addr       <= '0;
        skip       <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (accept) addr <= addr + 1'b1;
        skip <= (state == IDLE) ? '0 : skip_nxt;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rsp_data;
  end
endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Randomised-memory bench for vga_fetch_ctrl on a shrunken raster; pixel
// expectations come from position arithmetic, not from the design's internals.
module tb_vga_fetch_ctrl;
  localparam int HT = 48, HS = 13, HE = 44;
  localparam int VT = 24, VS = 5, VE = 20;
  localparam int AW = 19;
  localparam int HA = HE - HS + 1;
  localparam int FRAME_PIX = HA * (VE - VS + 1);

  logic          pclk = 1'b0;
  logic          reset, enable;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [23:0]   mem_rsp_data, pix_data;
  logic          underflow, frame_start;

  vga_fetch_ctrl #(
    .H_TOTAL(HT), .H_ACT_S(HS), .H_ACT_E(HE),
    .V_TOTAL(VT), .V_ACT_S(VS), .V_ACT_E(VE),
    .FIFO_DEPTH(16), .ADDR_W(AW)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .pix_data(pix_data), .underflow(underflow), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0;
  int cyc;
  // memory model: 0 always ready, 1 never ready, 2 ready one cycle in four, 3 random
  int ready_mode;
  bit hold_rsp;
  int release_cnt;
  logic [AW-1:0] mq[$];
  logic [AW-1:0] acc_log[$];
  int n_acc;
  logic [AW-1:0] last_addr;
  bit arm_first;
  int first_acc_y, first_acc_addr;
  int pix_mode, pix_bad, pix_nz, fs_bad = 0, hold_bad = 0;
  logic s_valid, s_uf, s_fs;
  logic [AW-1:0] s_addr, prev_addr, stall_addr;
  logic [23:0] s_pix;
  bit prev_stall;

  function automatic int rx(); return cyc % HT + 1; endfunction
  function automatic int ry(); return (cyc / HT) % VT + 1; endfunction
  function automatic bit ractive();
    return rx() >= HS && rx() <= HE && ry() >= VS && ry() <= VE;
  endfunction
  function automatic int raddr(); return (ry() - VS) * HA + (rx() - HS); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    s_valid = mem_req_valid; s_addr = mem_req_addr; s_pix = pix_data;
    s_uf = underflow; s_fs = frame_start;
  endtask

  task automatic service();
    logic rdy;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mq.size() > 0 && (!hold_rsp || release_cnt > 0)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 24'(mq.pop_front());
      if (hold_rsp) release_cnt--;
    end
    case (ready_mode)
      0:       rdy = 1'b1;
      2:       rdy = (cyc % 4 == 0);
      3:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = 1'b0;
    endcase
    mem_req_ready = rdy;
    if (s_valid && rdy) begin
      mq.push_back(s_addr);
      acc_log.push_back(s_addr);
      n_acc++;
      last_addr = s_addr;
      if (arm_first) begin
        arm_first = 1'b0; first_acc_y = ry(); first_acc_addr = int'(s_addr);
      end
    end
    prev_stall = s_valid && !rdy;
    prev_addr  = s_addr;
  endtask

  task automatic tick();
    @(negedge pclk);
    cyc++;
    sample();
    if (prev_stall && !(s_valid === 1'b1 && s_addr === prev_addr)) hold_bad++;
    if (s_fs !== (rx() == 1 && ry() == 1)) fs_bad++;
    if (s_pix !== 24'd0) pix_nz++;
    case (pix_mode)
      1: if (s_pix !== (ractive() ? 24'(raddr()) : 24'd0)) pix_bad++;
      2: if (!ractive() ? (s_pix !== 24'd0)
                        : (s_pix !== 24'd0 && s_pix !== 24'(raddr()))) pix_bad++;
      default: ;
    endcase
    service();
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    do begin tick(); n++; end while (!(rx() == x && ry() == y) && n < 3 * HT * VT);
    if (!(rx() == x && ry() == y)) begin
      checks++; errors++;
      $error("FAIL run_to position=(%0d,%0d) required=(%0d,%0d)", rx(), ry(), x, y);
    end
  endtask

  task automatic do_reset(input int n, input bit keep_q);
    reset = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (n) @(negedge pclk);
    reset = 1'b0;
    cyc = 0;
    if (!keep_q) mq.delete();
    acc_log.delete();
    ready_mode = 0; hold_rsp = 1'b0; release_cnt = 0; arm_first = 1'b0;
    n_acc = 0; prev_stall = 1'b0; pix_mode = 0; pix_bad = 0; pix_nz = 0;
    sample();
    chk("rst_valid", s_valid, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_pix", s_pix, 0);
    chk("rst_underflow", s_uf, 0);
    chk("rst_frame_start", s_fs, 0);
    service();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // ideal memory, enable from reset
    enable = 1'b1;
    do_reset(2, 1'b0);
    pix_mode = 1;
    run_to(HS, VS);     chk("t1_first_pix", s_pix, 0);
    run_to(HE, VS);     chk("t1_line_end", s_pix, HA - 1);
    run_to(HS, VS + 1); chk("t1_row1_start", s_pix, HA);
    run_to(HE, VE);     chk("t1_last_pix", s_pix, FRAME_PIX - 1);
    run_to(1, 1);
    chk("t1_frame_start", s_fs, 1);
    chk("t1_underflow", s_uf, 0);
    chk("t1_req_count", n_acc, FRAME_PIX);
    chk("t1_last_req", last_addr, FRAME_PIX - 1);
    run_to(HS + 1, VS); chk("t1_f2_pix1", s_pix, 1);
    chk("t1_pixels", pix_bad, 0);

    // responses withheld: credit limit
    do_reset(2, 1'b0);
    hold_rsp = 1'b1;
    repeat (60) tick();
    chk("t2_req_count", n_acc, 16);
    chk("t2_valid_low", s_valid, 0);
    begin
      int seq_bad = 0;
      foreach (acc_log[i]) if (acc_log[i] !== AW'(i)) seq_bad++;
      chk("t2_addr_seq", seq_bad, 0);
    end
    run_to(HS + 2, VS);
    release_cnt = 1;
    repeat (10) tick();
    chk("t2_req_count2", n_acc, 17);
    chk("t2_addr16", last_addr, 16);
    chk("t2_valid_low2", s_valid, 0);

    // back-pressure mid-FILL
    do_reset(2, 1'b0);
    run_to(HS + 5, VS);
    ready_mode = 1;
    tick();
    stall_addr = s_addr;
    chk("t3_stall_valid", s_valid, 1);
    chk("t3_stall_addr", s_addr, last_addr + 1);
    begin
      int hb = 0;
      repeat (10) begin
        tick();
        if (!(s_valid === 1'b1 && s_addr === stall_addr)) hb++;
      end
      chk("t3_hold", hb, 0);
    end
    ready_mode = 0;
    tick();
    chk("t3_accepted", last_addr, stall_addr);
    tick();
    chk("t3_next_addr", s_addr, stall_addr + 1);

    // starved memory: underflow with alignment kept
    do_reset(2, 1'b0);
    ready_mode = 2;
    pix_mode = 2;
    run_to(1, 1);
    chk("t4_underflow", s_uf, 1);
    chk("t4_aligned", pix_bad, 0);
    chk("t4_some_pixels", pix_nz > 0, 1);
    pix_mode = 0;
    run_to(HS + 1, VS); chk("t4_f2_pix1", s_pix, 1);

    // random ready throttling: every shown pixel still aligned
    do_reset(2, 1'b0);
    ready_mode = 3;
    pix_mode = 2;
    run_to(1, 1);
    chk("t4r_aligned", pix_bad, 0);

    // late enable
    enable = 1'b0;
    do_reset(2, 1'b0);
    run_to(1, 10);
    chk("t5_no_req", n_acc, 0);
    chk("t5_pix_zero", pix_nz, 0);
    enable = 1'b1;
    arm_first = 1'b1; first_acc_y = -1; first_acc_addr = -1;
    run_to(1, 1);
    chk("t5_frame_start", s_fs, 1);
    chk("t5_no_req_before_wrap", n_acc, 0);
    repeat (20) tick();
    chk("t5_first_y", first_acc_y, 1);
    chk("t5_first_addr", first_acc_addr, 0);

    // reset mid-frame with 5 outstanding
    do_reset(2, 1'b0);
    hold_rsp = 1'b1;
    ready_mode = 1;
    run_to(1, 12);
    ready_mode = 0;
    repeat (5) tick();
    ready_mode = 1;
    tick();
    chk("t6_outstanding", n_acc, 5);
    chk("t6_uf_before", s_uf, 1);
    enable = 1'b0;
    do_reset(1, 1'b1);
    chk("t6_x", dut.x_cnt, 1);
    chk("t6_y", dut.y_cnt, 1);
    repeat (8) tick();
    chk("t6_stale_gone", mq.size(), 0);
    enable = 1'b1;
    arm_first = 1'b1; first_acc_addr = -1;
    pix_mode = 1;
    run_to(HS + 1, VS); chk("t6_pix1", s_pix, 1);
    chk("t6_first_addr", first_acc_addr, 0);
    run_to(1, 1);
    chk("t6_pixels", pix_bad, 0);
    chk("t6_underflow", s_uf, 0);

    chk("frame_start_all", fs_bad, 0);
    chk("req_hold_all", hold_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
